// File: rtl/line_merge_pkg.sv
// Shared types and helpers for the line merge engine and its score lookup.
// Contents:
//   state_t      - engine FSM states
//   EMPTY        - exponent value that marks an empty tile
//   DEF_*        - default tile exponent width, score width and win exponent
//   sat_exp_inc  - exponent + 1, clamped to the largest exponent an ew-bit tile can hold
package line_merge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned EMPTY       = 0;
   localparam int          DEF_EW      = 4;
   localparam int          DEF_SW      = 16;
   localparam int          DEF_WIN_EXP = 11;

   function automatic int unsigned sat_exp_inc(input int unsigned e, input int unsigned ew);
      int unsigned top;
      top = (32'd1 << ew) - 32'd1;
      return (e >= top) ? top : e + 32'd1;
   endfunction

endpackage

// File: rtl/line_merge_score_lut.sv
// Combinational score lookup for one merge.
// Turns the exponent of the two tiles being merged into the score value
// 2^(e+1), saturated to SW bits. The board controller reuses this block for
// its score display.
// Ports:
//   e      in  EW  exponent of the tiles being merged
//   value  out SW  2^(e+1), or all ones when that does not fit in SW bits
module merge_score_lut #(
   parameter int EW = line_merge_pkg::DEF_EW,
   parameter int SW = line_merge_pkg::DEF_SW
) (
   input  logic [EW-1:0] e,
   output logic [SW-1:0] value
);

   int unsigned sh;

   always_comb begin
      sh = 32'(e) + 32'd1;
      if (sh >= 32'(SW)) value = '1;
      else               value = {{(SW-1){1'b0}}, 1'b1} << sh;
   end

endmodule

// File: rtl/line_merge_engine.sv
// Sequential 2048-style slide-and-merge engine for one board line.
// Scans one tile per cycle in slide order, compacts the non-empty tiles and
// merges equal neighbours, then maps the result back to board index order.
// Ports:
//   clk        in  1     system clock, rising edge
//   clr        in  1     asynchronous active-low reset
//   start      in  1     request, sampled in IDLE only
//   dir        in  1     0 = slide toward index 0, 1 = toward index N-1
//   line_in    in  N*EW  tile exponents, tile i at [i*EW +: EW]
//   busy       out 1     operation in progress
//   done       out 1     one-cycle pulse, results valid from this cycle
//   line_out   out N*EW  merged line, same packing as line_in
//   moved      out 1     line_out differs from the captured line_in
//   score_inc  out SW    saturating sum of merged tile values
//   win        out 1     a merge produced an exponent >= WIN_EXP
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | N cycles, one tile per cycle, in slide order
// FLUSH | write any pending tile, publish results
// DONE  | done pulse, then back to IDLE
module line_merge_engine
   import line_merge_pkg::*;
#(
   parameter int N       = 4,
   parameter int EW      = DEF_EW,
   parameter int SW      = DEF_SW,
   parameter int WIN_EXP = DEF_WIN_EXP
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic            dir,
   input  logic [N*EW-1:0] line_in,
   output logic            busy,
   output logic            done,
   output logic [N*EW-1:0] line_out,
   output logic            moved,
   output logic [SW-1:0]   score_inc,
   output logic            win
);

   localparam int IW  = $clog2(N);
   localparam int WPW = $clog2(N) + 1;

   state_t               state;
   logic [N-1:0][EW-1:0] line_cap;
   logic [N-1:0][EW-1:0] work;
   logic [N-1:0][EW-1:0] work_nxt;
   logic [N-1:0][EW-1:0] flush_line;
   logic [N-1:0][EW-1:0] mapped;
   logic                 dir_cap;
   logic [IW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [WPW-1:0]       wp;
   logic [WPW-1:0]       wp_nxt;
   logic [EW-1:0]        pend;
   logic [EW-1:0]        pend_nxt;
   logic [EW-1:0]        tile;
   logic [EW-1:0]        merged;
   logic [EW-1:0]        wr_val;
   logic                 wr_en;
   logic [SW-1:0]        score;
   logic [SW-1:0]        score_nxt;
   logic [SW-1:0]        lut_val;
   logic [SW:0]          score_sum;
   logic                 win_acc;
   logic                 win_nxt;

   merge_score_lut #(.EW(EW), .SW(SW)) u_lut (
      .e     (tile),
      .value (lut_val)
   );

   // cnt counts down N-1..0; dir=0 walks indices upward, dir=1 downward.
   always_comb begin
      idx       = dir_cap ? cnt : (IW'(N-1) - cnt);
      tile      = line_cap[idx];
      merged    = EW'(sat_exp_inc(32'(tile), 32'(EW)));
      score_sum = {1'b0, score} + {1'b0, lut_val};
      wr_en     = 1'b0;
      wr_val    = '0;
      wp_nxt    = wp;
      pend_nxt  = pend;
      score_nxt = score;
      win_nxt   = win_acc;
      if (tile != EW'(EMPTY)) begin
         if (pend == EW'(EMPTY)) begin
            pend_nxt = tile;
         end else if (pend == tile) begin
            // Emptying pending here is what stops a merged tile merging again.
            wr_en     = 1'b1;
            wr_val    = merged;
            wp_nxt    = wp + WPW'(1);
            pend_nxt  = EW'(EMPTY);
            score_nxt = score_sum[SW] ? '1 : score_sum[SW-1:0];
            if (32'(merged) >= 32'(WIN_EXP)) win_nxt = 1'b1;
         end else begin
            wr_en    = 1'b1;
            wr_val   = pend;
            wp_nxt   = wp + WPW'(1);
            pend_nxt = tile;
         end
      end
      work_nxt = work;
      for (int k = 0; k < N; k++) begin
         if (wr_en && wp == WPW'(k)) work_nxt[k] = wr_val;
      end
   end

   always_comb begin
      flush_line = work;
      for (int k = 0; k < N; k++) begin
         if (pend != EW'(EMPTY) && wp == WPW'(k)) flush_line[k] = pend;
      end
      for (int k = 0; k < N; k++) begin
         mapped[k] = dir_cap ? flush_line[N-1-k] : flush_line[k];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         line_cap  <= '0;
         work      <= '0;
         dir_cap   <= 1'b0;
         cnt       <= '0;
         wp        <= '0;
         pend      <= '0;
         score     <= '0;
         win_acc   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         line_out  <= '0;
         moved     <= 1'b0;
         score_inc <= '0;
         win       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  line_cap <= line_in;
                  dir_cap  <= dir;
                  work     <= '0;
                  wp       <= '0;
                  pend     <= EW'(EMPTY);
                  score    <= '0;
                  win_acc  <= 1'b0;
                  cnt      <= IW'(N-1);
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               work    <= work_nxt;
               wp      <= wp_nxt;
               pend    <= pend_nxt;
               score   <= score_nxt;
               win_acc <= win_nxt;
               if (cnt == '0) state <= FLUSH;
               else           cnt   <= cnt - IW'(1);
            end
            FLUSH: begin
               line_out  <= mapped;
               moved     <= (mapped != line_cap);
               score_inc <= score;
               win       <= win_acc;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_merge_engine.sv
module tb_line_merge_engine;

   localparam int N       = 4;
   localparam int EW      = 4;
   localparam int SW      = 16;
   localparam int WIN_EXP = 11;

   logic            clk = 1'b0;
   logic            clr;
   logic            start;
   logic            dir;
   logic [N*EW-1:0] line_in;
   logic            busy;
   logic            done;
   logic [N*EW-1:0] line_out;
   logic            moved;
   logic [SW-1:0]   score_inc;
   logic            win;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [N*EW-1:0] prev_line;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   line_merge_engine #(.N(N), .EW(EW), .SW(SW), .WIN_EXP(WIN_EXP)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .dir       (dir),
      .line_in   (line_in),
      .busy      (busy),
      .done      (done),
      .line_out  (line_out),
      .moved     (moved),
      .score_inc (score_inc),
      .win       (win)
   );

   typedef struct {
      logic        d;
      logic [15:0] lin;
      logic [15:0] lout;
      logic [15:0] sc;
      logic        mv;
      logic        wn;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t0;
      bit seen;
      @(negedge clk);
      dir = v.d; line_in = v.lin; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold"}, 32'(line_out), 32'(prev_line));
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      if (!seen) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_lat"},   32'(cyc - t0),  32'(N + 2));
         check({tag, "_line"},  32'(line_out),  32'(v.lout));
         check({tag, "_score"}, 32'(score_inc), 32'(v.sc));
         check({tag, "_moved"}, 32'(moved),     32'(v.mv));
         check({tag, "_win"},   32'(win),       32'(v.wn));
         check({tag, "_busy0"}, 32'(busy),      32'd0);
         @(negedge clk);
         check({tag, "_pulse"}, 32'(done),      32'd0);
         prev_line = v.lout;
      end
   endtask

   initial begin
      int t0;
      int ndone;
      bit seen;

      vecs[0]  = '{1'b0, pk(1,1,1,1),     pk(2,2,0,0),   16'd8,      1'b1, 1'b0};
      vecs[1]  = '{1'b0, pk(3,2,1,0),     pk(3,2,1,0),   16'd0,      1'b0, 1'b0};
      vecs[2]  = '{1'b0, pk(1,0,1,2),     pk(2,2,0,0),   16'd4,      1'b1, 1'b0};
      vecs[3]  = '{1'b1, pk(1,1,0,0),     pk(0,0,0,2),   16'd4,      1'b1, 1'b0};
      vecs[4]  = '{1'b1, pk(0,0,0,2),     pk(0,0,0,2),   16'd0,      1'b0, 1'b0};
      vecs[5]  = '{1'b0, pk(15,15,0,0),   pk(15,0,0,0),  16'hFFFF,   1'b1, 1'b1};
      vecs[6]  = '{1'b0, pk(10,10,0,0),   pk(11,0,0,0),  16'd2048,   1'b1, 1'b1};
      vecs[7]  = '{1'b1, pk(2,2,2,0),     pk(0,0,2,3),   16'd8,      1'b1, 1'b0};
      vecs[8]  = '{1'b0, pk(1,2,1,2),     pk(1,2,1,2),   16'd0,      1'b0, 1'b0};
      vecs[9]  = '{1'b0, pk(0,0,0,5),     pk(5,0,0,0),   16'd0,      1'b1, 1'b0};
      vecs[10] = '{1'b0, pk(14,14,14,14), pk(15,15,0,0), 16'hFFFF,   1'b1, 1'b1};

      clr = 1'b0; start = 1'b0; dir = 1'b0; line_in = '0; prev_line = '0;
      #12;
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_line",  32'(line_out),  32'd0);
      check("rst_score", 32'(score_inc), 32'd0);
      check("rst_moved", 32'(moved),     32'd0);
      check("rst_win",   32'(win),       32'd0);
      @(negedge clk);
      clr = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // start re-pulsed during SCAN must be ignored
      @(negedge clk);
      dir = 1'b0; line_in = pk(1,1,1,1); start = 1'b1; t0 = cyc;
      @(negedge clk);
      dir = 1'b1; line_in = pk(3,3,3,3);
      check("rescan_busy", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               check("rescan_lat",   32'(cyc - t0),  32'(N + 2));
               check("rescan_line",  32'(line_out),  32'(pk(2,2,0,0)));
               check("rescan_score", 32'(score_inc), 32'd8);
            end
         end
         @(negedge clk);
      end
      check("rescan_ndone", 32'(ndone), 32'd1);
      check("rescan_idle",  32'(busy),  32'd0);
      prev_line = pk(2,2,0,0);

      // start presented only in the DONE cycle is ignored
      @(negedge clk);
      dir = 1'b0; line_in = pk(3,2,1,0); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      check("dstart_seen", 32'(seen), 32'd1);
      line_in = pk(5,5,0,0); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("dstart_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("dstart_busy2", 32'(busy), 32'd0);
      check("dstart_hold",  32'(line_out), 32'(pk(3,2,1,0)));
      prev_line = pk(3,2,1,0);

      // reset in the middle of SCAN aborts immediately
      @(negedge clk);
      dir = 1'b0; line_in = pk(4,4,0,0); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("abort_busy",  32'(busy),      32'd0);
      check("abort_done",  32'(done),      32'd0);
      check("abort_line",  32'(line_out),  32'd0);
      check("abort_score", 32'(score_inc), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
      clr = 1'b1;
      prev_line = '0;
      run_vec(vecs[7], "post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_merge_engine.md
Name: line_merge_engine

Overview:
- Sequential 2048-style slide-and-merge engine for one row or column of the board.
- Generalised successor of the fixed four-tile, fixed-width line-change stub:
  - line length and tile exponent width are parameters;
  - direction is selectable;
  - operation is handshaked (start/busy/done).
- Adds score, moved and win outputs.
- Sits between the board register file and the VGA tile renderer. The board controller issues one line per start.

Parameters:
N, 4, tiles per line (>=2)
EW, 4, tile exponent width; 0 = empty tile, e = tile value 2^e
SW, 16, score_inc width
WIN_EXP, 11, exponent that flags a win (2048)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
start  in  1  request; sampled in IDLE only
dir  in  1  0 = slide toward index 0, 1 = slide toward index N-1; captured with start
line_in  in  N*EW  tile exponents, tile i at bits [i*EW +: EW]; captured with start
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; outputs valid from this cycle
line_out  out  N*EW  merged line, same packing as line_in
moved  out  1  line_out differs from captured line_in
score_inc  out  SW  sum of merged tile values, saturating
win  out  1  some merge produced exponent >= WIN_EXP

Behaviour:
- Reset (clr=0, async): state IDLE; busy, done, moved, win = 0; line_out and score_inc = 0. Reset mid-operation aborts immediately, with no partial results.
- States: IDLE -> SCAN (N cycles) -> FLUSH (1 cycle) -> DONE (1 cycle) -> IDLE.
- IDLE:
  - start=1 captures line_in and dir.
  - Clears the working line, write pointer wp, pending register, score and win.
  - Moves to SCAN.
- SCAN, one tile per cycle:
  - Index order is 0..N-1 for dir=0 and N-1..0 for dir=1.
  - Tile t = 0: skipped.
  - pending empty: pending <= t.
  - pending == t: write merge(t) at wp; wp advances; pending emptied; score += 2^(t+1).
  - pending != t: write pending at wp; wp advances; pending <= t.
- Merge rule: a tile produced by a merge never merges again. This is guaranteed because pending is emptied after each merge.
- FLUSH: if pending is non-empty, write it at wp. All unwritten slots remain 0.
- DONE:
  - done=1 and busy=0.
  - line_out is mapped back to the original index order: for dir=1, wp slot k is placed at index N-1-k.
  - moved = (line_out != captured line_in).
- Latency: start accepted at cycle T; done at T+N+2. The next start is accepted at T+N+3 at the earliest.
- Outputs hold their values until the next accepted start. On that start they are not cleared early; they update at the next done.
- start while busy or in DONE: ignored, no queuing.
- Saturation:
  - Merging two tiles of exponent 2^EW-1 yields 2^EW-1. It still counts as a merge.
  - score_inc saturates at 2^SW-1. This includes the case where 2^(t+1) itself exceeds SW bits.
- win is sticky within one operation. It is recomputed per operation.
- Tiles are unsigned exponents; there is no sign handling.

Decomposition:
- Shared package line_merge_pkg holds:
  - state enum (IDLE, SCAN, FLUSH, DONE);
  - EMPTY tile constant;
  - default EW/SW/WIN_EXP;
  - a function for the saturating exponent increment.
- One sub-module, merge_score_lut: combinational exponent -> saturated SW-bit score value 2^(e+1). It is reused by the board controller for the score display.

Test Plan:
- dir=0, line_in exps [1,1,1,1] -> line_out [2,2,0,0], score_inc 8, moved 1, win 0, done at T+6.
- dir=0, [3,2,1,0] -> [3,2,1,0], moved 0, score_inc 0; [1,0,1,2] -> [2,2,0,0], score_inc 4.
- dir=1, [1,1,0,0] -> [0,0,0,2], score_inc 4, moved 1; [0,0,0,2] dir=1 -> unchanged, moved 0.
- EW=4, SW=16: [15,15,0,0] -> [15,0,0,0], score_inc 0xFFFF; [10,10,0,0] -> [11,0,0,0], win 1, score_inc 2048.
- start pulsed again during SCAN -> ignored, single done, results match the first line.
- clr low during SCAN -> busy, done, line_out, score_inc all 0 immediately. After release, a new start completes normally.
